// File: rtl/alu_writeback.sv
// ----------------------------------------------------------------------------
// alu_writeback
//
// Writeback stage that sits directly behind the ALU. Each accepted ALU
// result is registered and offered to the register file over a valid/ready
// handshake. The stage also owns the architectural flag register {N,Z,C,V}
// and resolves beq/bne/jump into a one-cycle taken-branch pulse with target.
//
// Storage is an output register plus one skid register, so the ALU can issue
// one more result while the register file is stalled. in_ready is registered
// and is high exactly when the skid register is empty.
//
// Optional build macro:
//   WB_STICKY_OVF_EN  - when defined, the V flag is sticky: once an ARITH
//                       result sets it, it stays set through later ARITH and
//                       LOGIC updates until reset. A flush rollback still
//                       restores the value saved before the discarded entry.
// ----------------------------------------------------------------------------
module alu_writeback #(
    parameter int WIDTH       = 32,
    parameter int RA_W        = 5,
    parameter bit R0_WRITABLE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    // ALU side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,
    // Register-file side
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [RA_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    // Architectural flags and branch resolution
    output logic [3:0]       flags,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target,
    output logic             flush
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------

    // Occupancy of the two-entry buffer. TWO means output and skid both hold
    // an entry, which is the only state where in_ready is low.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_ARITH  = 2'd0,
        CLS_LOGIC  = 2'd1,
        CLS_BRANCH = 2'd2
    } op_class_e;

    // Everything the stage carries with a result until it retires. The
    // branch target is computed once at accept and travels with the entry.
    typedef struct packed {
        logic             we;
        logic [RA_W-1:0]  rd;
        logic [WIDTH-1:0] data;
        logic             is_branch;
        logic             taken;
        logic [WIDTH-1:0] target;
    } entry_t;

    // Every one of the 32 opcodes lands in exactly one class; anything that
    // is neither arithmetic nor a branch updates flags like a logic op.
    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        case (op)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: cls = CLS_ARITH;
            5'b00010, 5'b00111, 5'b01010: cls = CLS_BRANCH;
            default:                      cls = CLS_LOGIC;
        endcase
        return cls;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e     state_q,       state_d;
    entry_t     out_q,         out_d;
    entry_t     skid_q,        skid_d;
    logic [3:0] skid_shadow_q, skid_shadow_d;   // flags before the skid entry
    logic [3:0] flags_q,       flags_d;
    logic       in_ready_q,    in_ready_d;
    logic       br_taken_q,    br_taken_d;
    logic [WIDTH-1:0] br_target_q, br_target_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic      accept;
    logic      retire;
    logic      flush_now;
    op_class_e in_class;

    assign wb_valid  = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign retire    = wb_valid & wb_ready;
    // A taken branch leaving the output register squashes everything younger.
    assign flush_now = retire & out_q.is_branch & out_q.taken;
    assign in_class  = classify(in_opcode);

    // ------------------------------------------------------------------------
    // Build the entry and the flag update for the incoming result
    // ------------------------------------------------------------------------
    entry_t     new_entry;
    logic [3:0] new_flags;
    logic       res_n;
    logic       res_z;

    assign res_n = in_result[WIDTH-1];
    // Z always comes from the result itself; in_zero is only the branch test.
    assign res_z = (in_result == '0);

    // Decode the incoming ALU result into a buffer entry and next flags.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        new_entry           = '0;
        new_entry.rd        = in_rd;
        new_entry.data      = in_result;
        new_entry.target    = in_pc + in_imm;   // wraps modulo 2^WIDTH
        new_entry.is_branch = (in_class == CLS_BRANCH);
        new_entry.taken     = (in_class == CLS_BRANCH) & in_zero;
        new_entry.we        = (in_class != CLS_BRANCH) &
                              (R0_WRITABLE || (in_rd != '0));

        new_flags = flags_q;
        case (in_class)
            CLS_ARITH: begin
`ifdef WB_STICKY_OVF_EN
                new_flags = {res_n, res_z, in_carry, flags_q[0] | in_overflow};
`else
                new_flags = {res_n, res_z, in_carry, in_overflow};
`endif
            end
            CLS_LOGIC: begin
`ifdef WB_STICKY_OVF_EN
                new_flags = {res_n, res_z, 1'b0, flags_q[0]};
`else
                new_flags = {res_n, res_z, 1'b0, 1'b0};
`endif
            end
            default: new_flags = flags_q;       // branches leave flags alone
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state: buffer occupancy, entry movement, flags, branch pulse
    // ------------------------------------------------------------------------
    // Next-state logic for the two-entry buffer and the flag register.
    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        skid_d        = skid_q;
        skid_shadow_d = skid_shadow_q;
        flags_d       = flags_q;
        br_taken_d    = 1'b0;
        br_target_d   = br_target_q;

        if (flush_now) begin
            // Drop the skid entry and any result accepted on this edge. The
            // flags go back to what they were before the oldest dropped
            // entry; if only the same-edge input is dropped, flags_q already
            // is that value because its update is never applied.
            state_d     = ST_EMPTY;
            br_taken_d  = 1'b1;
            br_target_d = out_q.target;
            if (state_q == ST_TWO) begin
                flags_d = skid_shadow_q;
            end
        end else begin
            if (accept) begin
                flags_d = new_flags;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, retire})
                        2'b10: begin
                            skid_d        = new_entry;
                            skid_shadow_d = flags_q;
                            state_d       = ST_TWO;
                        end
                        2'b01: state_d = ST_EMPTY;
                        2'b11: out_d   = new_entry;
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    // in_ready is low here, so only a retire can happen.
                    if (retire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_TWO);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // State and payload registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the payload registers are cleared too, because wb_rd,
            // wb_data and br_target are visible outputs with defined reset
            // values and the skid contents would otherwise carry X into the
            // output register when it is next promoted.
            state_q       <= ST_EMPTY;
            out_q         <= '0;
            skid_q        <= '0;
            skid_shadow_q <= '0;
            flags_q       <= '0;
            in_ready_q    <= 1'b1;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values of the same edge regardless of statement order.
            state_q       <= state_d;
            out_q         <= out_d;
            skid_q        <= skid_d;
            skid_shadow_q <= skid_shadow_d;
            flags_q       <= flags_d;
            in_ready_q    <= in_ready_d;
            br_taken_q    <= br_taken_d;
            br_target_q   <= br_target_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign wb_we     = out_q.we;
    assign wb_rd     = out_q.rd;
    assign wb_data   = out_q.data;
    assign flags     = flags_q;
    assign br_taken  = br_taken_q;
    assign flush     = br_taken_q;
    assign br_target = br_target_q;

endmodule
